// File: rtl/alu_pkg.sv
// Shared opcodes, exception codes and FSM encoding for the
// execute-stage ALU sequencer.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_MUL   = 4'h4;
   localparam logic [3:0] OP_DIV   = 4'h8;
   localparam logic [3:0] OP_ANDI  = 4'hC;
   localparam logic [3:0] OP_ORI   = 4'hE;
   localparam logic [3:0] OP_ADDNF = 4'hF;

   localparam logic [1:0] EXC_NONE = 2'd0;
   localparam logic [1:0] EXC_DZ   = 2'd1;
   localparam logic [1:0] EXC_ILL  = 2'd2;
   localparam logic [1:0] EXC_OVF  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WB,
      S_ERR
   } state_t;

   function automatic logic op_legal(
      input logic [3:0] op
   );
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         op == OP_ADD,
         op == OP_SUB,
         op == OP_MUL,
         op == OP_DIV,
         op == OP_ANDI,
         op == OP_ORI,
         op == OP_ADDNF: ok = 1'b1;
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic int unsigned op_latency(
      input logic [3:0]  op,
      input int unsigned mul_c,
      input int unsigned div_c
   );
      int unsigned lat;
      lat = 1;
      unique case (1'b1)
         op == OP_MUL: lat = mul_c;
         op == OP_DIV: lat = div_c;
         default:      lat = 1;
      endcase
      return lat;
   endfunction

   // Logic ops never raise overflow even if the ALU flag is set
   function automatic logic op_ovf_chk(
      input logic [3:0] op
   );
      return (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_MUL) || (op == OP_DIV) ||
             (op == OP_ADDNF);
   endfunction

   function automatic logic op_has_r0(
      input logic [3:0] op
   );
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request and writeback handshakes of the ALU sequencer.
interface alu_seq_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_rd;

   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        wb_r0_en;
   logic [15:0] wb_r0_data;

   modport master (
      output req_valid, req_op, req_a,
             req_b, req_rd, wb_ready,
      input  req_ready, wb_valid, wb_rd,
             wb_data, wb_r0_en, wb_r0_data
   );

   modport slave (
      input  req_valid, req_op, req_a,
             req_b, req_rd, wb_ready,
      output req_ready, wb_valid, wb_rd,
             wb_data, wb_r0_en, wb_r0_data
   );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer: issues one op to the ALU, waits out
// its latency, captures the result and raises exceptions.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 4,
   parameter int CNT_W      = 3
) (
   input  logic           clk,
   input  logic           reset,
   alu_seq_ctrl_if.slave  bus,
   output logic [15:0]    alu_in1,
   output logic [15:0]    alu_in2,
   output logic [3:0]     alu_ctrl,
   input  logic [15:0]    alu_out,
   input  logic [15:0]    alu_r0,
   input  logic           alu_ovf,
   output logic           exc_valid,
   output logic [1:0]     exc_code
);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         alu_in1        <= '0;
         alu_in2        <= '0;
         alu_ctrl       <= '0;
         exc_valid      <= 1'b0;
         exc_code       <= EXC_NONE;
         bus.req_ready  <= 1'b1;
         bus.wb_valid   <= 1'b0;
         bus.wb_rd      <= '0;
         bus.wb_data    <= '0;
         bus.wb_r0_en   <= 1'b0;
         bus.wb_r0_data <= '0;
      end else begin
         exc_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  bus.req_ready <= 1'b0;
                  if (!op_legal(bus.req_op)) begin
                     state     <= S_ERR;
                     exc_valid <= 1'b1;
                     exc_code  <= EXC_ILL;
                  end else if (bus.req_op == OP_DIV &&
                               bus.req_b == 16'h0) begin
                     // Screened here so the ALU never divides by zero
                     state     <= S_ERR;
                     exc_valid <= 1'b1;
                     exc_code  <= EXC_DZ;
                  end else begin
                     alu_in1   <= bus.req_a;
                     alu_in2   <= bus.req_b;
                     alu_ctrl  <= bus.req_op;
                     bus.wb_rd <= bus.req_rd;
                     cnt       <= CNT_W'(op_latency(
                                    bus.req_op,
                                    MUL_CYCLES,
                                    DIV_CYCLES) - 1);
                     state     <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  bus.wb_data    <= alu_out;
                  bus.wb_r0_data <= alu_r0;
                  bus.wb_r0_en   <= op_has_r0(alu_ctrl);
                  bus.wb_valid   <= 1'b1;
                  if (alu_ovf && op_ovf_chk(alu_ctrl)) begin
                     exc_valid <= 1'b1;
                     exc_code  <= EXC_OVF;
                  end
                  alu_ctrl <= 4'h0;
                  state    <= S_WB;
               end
            end
            S_WB: begin
               if (bus.wb_ready) begin
                  bus.wb_valid  <= 1'b0;
                  bus.req_ready <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            S_ERR: begin
               bus.req_ready <= 1'b1;
               state         <= S_IDLE;
            end
            default: begin
               bus.req_ready <= 1'b1;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed plus random bench for alu_seq_ctrl with a
// behavioural ALU and an independent expected-value model.
module tb_alu_seq_ctrl;

   localparam int MULC = 2;
   localparam int DIVC = 4;

   logic        clk;
   logic        reset;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [3:0]  alu_ctrl;
   logic [15:0] alu_out;
   logic [15:0] alu_r0;
   logic        alu_ovf;
   logic        exc_valid;
   logic [1:0]  exc_code;

   int checks = 0;
   int errors = 0;
   bit dz_seen = 1'b0;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl #(
      .MUL_CYCLES (MULC),
      .DIV_CYCLES (DIVC),
      .CNT_W      (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_ctrl  (alu_ctrl),
      .alu_out   (alu_out),
      .alu_r0    (alu_r0),
      .alu_ovf   (alu_ovf),
      .exc_valid (exc_valid),
      .exc_code  (exc_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {ovf, r0, out} of a 16-bit signed ALU
   function automatic logic [32:0] alu_ref(
      input logic [3:0]  op,
      input logic [15:0] a,
      input logic [15:0] b
   );
      int sa, sb, r, q;
      logic [15:0] o, h;
      logic v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r = 0; q = 0; o = '0; h = '0; v = 1'b0;
      case (op)
         4'h1, 4'hF: begin
            r = sa + sb; o = r[15:0];
            v = (r > 32767) || (r < -32768);
         end
         4'h2: begin
            r = sa - sb; o = r[15:0];
            v = (r > 32767) || (r < -32768);
         end
         4'h4: begin
            r = sa * sb; o = r[15:0]; h = r[31:16];
            v = (r > 32767) || (r < -32768);
         end
         4'h8: if (sb != 0) begin
            q = sa / sb; r = sa % sb;
            o = q[15:0]; h = r[15:0];
            v = (q > 32767);
         end
         4'hC: o = a & b;
         4'hE: o = a | b;
         default: o = '0;
      endcase
      return {v, h, o};
   endfunction

   always_comb begin
      {alu_ovf, alu_r0, alu_out} =
         alu_ref(alu_ctrl, alu_in1, alu_in2);
   end

   always @(negedge clk)
      if (alu_ctrl == 4'h8 && alu_in2 == 16'h0)
         dz_seen <= 1'b1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_op(
      input logic [3:0]  op,
      input logic [15:0] a,
      input logic [15:0] b,
      input logic [3:0]  rd,
      input int          d,
      input bit          noise
   );
      logic [32:0] e;
      logic [15:0] held;
      bit legal, ovf_exc, r0;
      int lat, i;
      legal = op inside {4'h1, 4'h2, 4'h4, 4'h8,
                         4'hC, 4'hE, 4'hF};
      lat = (op == 4'h4) ? MULC :
            (op == 4'h8) ? DIVC : 1;
      r0 = (op == 4'h4) || (op == 4'h8);
      e = alu_ref(op, a, b);
      ovf_exc = e[32] && (op inside {4'h1, 4'h2,
                          4'h4, 4'h8, 4'hF});
      chk("ready_idle", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_op = op;
      bus.req_a = a;
      bus.req_b = b;
      bus.req_rd = rd;
      step();
      bus.req_valid = noise;
      bus.req_op = 4'h2;
      bus.req_a = 16'($urandom);
      bus.req_b = 16'($urandom);
      if (!legal || (op == 4'h8 && b == 16'h0)) begin
         chk("err_exc", 32'(exc_valid), 1);
         chk("err_code", 32'(exc_code), legal ? 1 : 2);
         chk("err_nowb", 32'(bus.wb_valid), 0);
         chk("err_ctrl", 32'(alu_ctrl), 0);
         chk("err_rdy", 32'(bus.req_ready), 0);
         step();
         chk("err_pulse", 32'(exc_valid), 0);
         chk("err_nowb2", 32'(bus.wb_valid), 0);
         chk("err_back", 32'(bus.req_ready), 1);
      end else begin
         chk("iss_ctrl", 32'(alu_ctrl), 32'(op));
         chk("iss_a", 32'(alu_in1), 32'(a));
         chk("iss_b", 32'(alu_in2), 32'(b));
         chk("iss_rdy", 32'(bus.req_ready), 0);
         i = 0;
         while (!bus.wb_valid && i < 20) begin
            chk("exec_noexc", 32'(exc_valid), 0);
            chk("exec_hold", 32'(alu_ctrl), 32'(op));
            step();
            i++;
         end
         chk("wb_latency", i, lat);
         chk("wb_rd", 32'(bus.wb_rd), 32'(rd));
         chk("wb_data", 32'(bus.wb_data), 32'(e[15:0]));
         chk("wb_r0en", 32'(bus.wb_r0_en), 32'(r0));
         if (r0)
            chk("wb_r0", 32'(bus.wb_r0_data),
                32'(e[31:16]));
         chk("ovf_exc", 32'(exc_valid), 32'(ovf_exc));
         if (ovf_exc)
            chk("ovf_code", 32'(exc_code), 3);
         chk("wb_ctrl0", 32'(alu_ctrl), 0);
         chk("wb_rdy", 32'(bus.req_ready), 0);
         held = bus.wb_data;
         for (int k = 0; k < d; k++) begin
            step();
            chk("bp_valid", 32'(bus.wb_valid), 1);
            chk("bp_data", 32'(bus.wb_data), 32'(held));
            chk("bp_rdy", 32'(bus.req_ready), 0);
            chk("bp_noexc", 32'(exc_valid), 0);
         end
         bus.wb_ready = 1'b1;
         step();
         bus.wb_ready = 1'b0;
         chk("hs_valid", 32'(bus.wb_valid), 0);
         chk("hs_rdy", 32'(bus.req_ready), 1);
      end
      bus.req_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  op;
      logic [15:0] a, b;
      reset = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_rd = '0;
      bus.wb_ready = 1'b0;
      step();
      step();
      chk("rst_ready", 32'(bus.req_ready), 1);
      chk("rst_wbv", 32'(bus.wb_valid), 0);
      chk("rst_exc", 32'(exc_valid), 0);
      chk("rst_code", 32'(exc_code), 0);
      chk("rst_ctrl", 32'(alu_ctrl), 0);
      chk("rst_in1", 32'(alu_in1), 0);
      chk("rst_data", 32'(bus.wb_data), 0);
      reset = 1'b1;
      step();

      do_op(4'h1, 16'd7, 16'd5, 4'd3, 0, 1'b0);
      chk("add_val", 32'(bus.wb_data), 12);
      do_op(4'h4, 16'd300, 16'd300, 4'd6, 1, 1'b0);
      chk("mul_lo", 32'(bus.wb_data), 32'h5F90);
      chk("mul_hi", 32'(bus.wb_r0_data), 32'h0001);
      do_op(4'h8, 16'd17, 16'd5, 4'd9, 3, 1'b1);
      chk("div_q", 32'(bus.wb_data), 3);
      chk("div_r", 32'(bus.wb_r0_data), 2);
      do_op(4'h8, 16'd17, 16'd0, 4'd1, 0, 1'b0);
      chk("dz_code", 32'(exc_code), 1);
      do_op(4'h3, 16'd1, 16'd2, 4'd1, 0, 1'b0);
      chk("ill_code", 32'(exc_code), 2);
      do_op(4'h1, 16'h7FFF, 16'h0001, 4'd2, 0, 1'b0);
      chk("ovf_data", 32'(bus.wb_data), 32'h8000);
      chk("ovf_hold", 32'(exc_code), 3);

      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom_range(0, 15));
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 3) == 0) b = 16'h0;
         if ($urandom_range(0, 4) == 0) a = 16'h7FFF;
         do_op(op, a, b, 4'($urandom),
               int'($urandom_range(0, 3)),
               1'($urandom));
      end

      bus.req_valid = 1'b1;
      bus.req_op = 4'h8;
      bus.req_a = 16'd100;
      bus.req_b = 16'd7;
      bus.req_rd = 4'd5;
      step();
      bus.req_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mrst_ready", 32'(bus.req_ready), 1);
      chk("mrst_wbv", 32'(bus.wb_valid), 0);
      chk("mrst_exc", 32'(exc_valid), 0);
      chk("mrst_ctrl", 32'(alu_ctrl), 0);
      chk("mrst_in1", 32'(alu_in1), 0);
      chk("mrst_in2", 32'(alu_in2), 0);
      chk("mrst_rd", 32'(bus.wb_rd), 0);
      chk("mrst_r0en", 32'(bus.wb_r0_en), 0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("mrst_nowb", 32'(bus.wb_valid), 0);
         chk("mrst_noexc", 32'(exc_valid), 0);
      end
      do_op(4'hC, 16'hF0F0, 16'h3C3C, 4'd7, 0, 1'b0);
      chk("andi_val", 32'(bus.wb_data), 32'h3030);
      chk("no_dz_seen", 32'(dz_seen), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Execute-stage sequencer for the 16-bit ALU (ops add, sub, mul, div, ANDI, ORI, add-no-func).
- Accepts one operation at a time over a valid/ready request interface and registers operands into the ALU.
- Models multi-cycle latency for mul/div, then captures result and R0 (high product or remainder) for writeback.
- Screens illegal opcodes and divide-by-zero before issue; reports overflow alongside writeback.

Parameters:
MUL_CYCLES, 2, cycles ALU result is allowed to settle for mul (min 1)
DIV_CYCLES, 4, cycles ALU result is allowed to settle for div (min 1)
CNT_W, 3, width of latency counter; must hold max(MUL_CYCLES,DIV_CYCLES)-1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_op  in  4  ALU ctrl code
req_a  in  16  operand 1 (signed)
req_b  in  16  operand 2 (signed)
req_rd  in  4  destination register index
alu_in1  out  16  registered operand 1 to ALU
alu_in2  out  16  registered operand 2 to ALU
alu_ctrl  out  4  registered ctrl to ALU; 4'h0 when not executing
alu_out  in  16  ALU result
alu_r0  in  16  ALU high product / remainder
alu_ovf  in  1  ALU overflow flag
wb_valid  out  1  writeback data valid
wb_ready  in  1  writeback consumer accepts
wb_rd  out  4  destination index
wb_data  out  16  captured alu_out
wb_r0_en  out  1  R0 must be written (mul, div)
wb_r0_data  out  16  captured alu_r0
exc_valid  out  1  one-cycle exception pulse
exc_code  out  2  0 none, 1 div-by-zero, 2 illegal op, 3 overflow

Behaviour:
- Reset (reset==0 at posedge): state IDLE, counter 0. All outputs 0 except req_ready=1. Applies mid-operation too: in-flight op is dropped, no wb_valid or exc_valid follows.
- States: IDLE, EXEC, WB, ERR.
- Legal ops: 1,2,4,8,C,E,F. Latency LAT = MUL_CYCLES for 4, DIV_CYCLES for 8, 1 otherwise.
- IDLE: on req_valid at cycle T:
  - Illegal op -> ERR, exc_code=2.
  - op 8 with req_b==0 -> ERR, exc_code=1; ALU never sees div-by-zero operands.
  - Otherwise latch a/b/op/rd into alu_in1/alu_in2/alu_ctrl/wb_rd, counter=LAT-1 -> EXEC.
- EXEC: alu_* outputs held stable.
  - counter!=0: decrement.
  - counter==0: capture wb_data=alu_out; wb_r0_data=alu_r0; wb_r0_en=(op==4||op==8).
  - Same cycle: if alu_ovf && op in {1,2,4,8,F}, pulse exc_valid with exc_code=3.
  - Set alu_ctrl=0, go to WB. wb_valid rises at cycle T+1+LAT.
- WB: wb_valid=1; wb_* held until wb_ready sampled high.
  - On handshake: wb_valid=0, go to IDLE; req_ready=1 the next cycle.
  - wb_ready high on the first WB cycle gives a one-cycle wb_valid.
- ERR: exc_valid=1 for exactly one cycle (cycle T+1), no writeback, then IDLE.
- Overflow still writes back data; exc is advisory, coincident with capture.
- req_ready low in EXEC/WB/ERR; requests then are ignored, not queued.
- Throughput: at most one op per LAT+2 cycles, or LAT+3 if wb_ready is held low.
- exc_code holds its last value between pulses; it is meaningful only while exc_valid=1.

Decomposition:
- Package alu_pkg: opcode localparams OP_ADD=1, OP_SUB=2, OP_MUL=4, OP_DIV=8, OP_ANDI=C, OP_ORI=E, OP_ADDNF=F.
- Package also holds exc_code constants and the state encoding.
- Function op_legal(op) and function op_latency(op) live in alu_pkg.
- No sub-module; the ALU is instantiated beside this block in the execute stage, not inside it.

Test Plan:
- ADD: op=1, a=7, b=5, rd=3 at T -> wb_valid at T+2, wb_data=12, wb_rd=3, wb_r0_en=0, exc_valid never high.
- MUL: op=4, a=300, b=300 -> wb_valid at T+3, wb_data=16'h5F90, wb_r0_data=16'h0001, wb_r0_en=1.
- DIV and backpressure: op=8, a=17, b=5, wb_ready low 3 cycles -> wb_valid from T+5 to handshake, wb_data=3, wb_r0_data=2; req_ready low throughout.
- Errors: op=8, b=0 -> exc_valid at T+1 with code 1, no wb_valid, alu_ctrl stays 0. Then op=4'h3 -> exc code 2.
- Overflow: op=1, a=16'h7FFF, b=1 (ALU asserts alu_ovf) -> wb_data=16'h8000 written, exc_valid code 3 coincident with capture.
- Reset mid-DIV: reset=0 for one cycle at T+2 -> next cycle IDLE, req_ready=1, all other outputs 0, no wb_valid for the dropped op.
